// File: rtl/mipi_rx_packet_sequencer.sv
// mipi_rx_packet_sequencer
// Packet-level controller behind the 4-lane CSI-2 lane aligner. It parses the
// packet header in the first aligned word and counts long-packet payload
// against the word count. It emits byte-enabled payload words and
// frame/line sync pulses. At every packet end it asks the aligner chain to
// resync, so the next packet hunts for its sync sequence again.

module mipi_rx_packet_sequencer #(
    parameter logic       VC_FILTER_EN = 1'b0,
    parameter logic [1:0] VC_SEL       = 2'd0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        lane_valid_i,
    input  logic [31:0] lane_byte_i,
    output logic        payload_valid_o,
    output logic [31:0] payload_o,
    output logic [3:0]  payload_be_o,
    output logic [1:0]  vc_o,
    output logic [5:0]  dt_o,
    output logic [15:0] wc_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        line_start_o,
    output logic        line_end_o,
    output logic        packet_done_o,
    output logic        aligner_clear_o,
    output logic        err_truncated_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_FLUSH
    } state_t;

    state_t state_q;
    state_t state_d;

    // bytes_left counts payload plus the two CRC bytes; data_left counts payload only
    logic [16:0] bytes_left_q;
    logic [16:0] bytes_left_d;
    logic [15:0] data_left_q;
    logic [15:0] data_left_d;
    logic        filtered_q;
    logic        filtered_d;

    // next values of the registered outputs
    logic        payload_valid_d;
    logic [31:0] payload_d;
    logic [3:0]  payload_be_d;
    logic [1:0]  vc_d;
    logic [5:0]  dt_d;
    logic [15:0] wc_d;
    logic        frame_start_d;
    logic        frame_end_d;
    logic        line_start_d;
    logic        line_end_d;
    logic        packet_done_d;
    logic        aligner_clear_d;
    logic        err_truncated_d;

    // header decode of the incoming word; only meaningful in IDLE
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_is_long;

    // payload bookkeeping helpers
    logic        is_last_word;
    logic [15:0] data_take;
    logic [3:0]  be_for_word;

    assign hdr_vc      = lane_byte_i[7:6];
    assign hdr_dt      = lane_byte_i[5:0];
    assign hdr_wc      = lane_byte_i[23:8];
    assign hdr_is_long = (hdr_dt >= 6'h10);

    assign is_last_word = (bytes_left_q <= 17'd4);
    assign data_take    = (data_left_q >= 16'd4) ? 16'd4 : data_left_q;

    // byte enables narrow only on the word that carries the tail of the payload
    always_comb begin
        be_for_word = 4'hF;
        if (data_left_q < 16'd4) begin
            case (data_left_q[1:0])
                2'd3:    be_for_word = 4'h7;
                2'd2:    be_for_word = 4'h3;
                2'd1:    be_for_word = 4'h1;
                default: be_for_word = 4'h0;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic: header -> payload or flush, last word or gap -> flush
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lane_valid_i) begin
                    state_d = hdr_is_long ? ST_PAYLOAD : ST_FLUSH;
                end
            end
            ST_PAYLOAD: begin
                if (!lane_valid_i || is_last_word) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!lane_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // output and counter next-values; header fields and payload data hold unless updated
    always_comb begin
        payload_valid_d = 1'b0;
        payload_d       = payload_o;
        payload_be_d    = payload_be_o;
        vc_d            = vc_o;
        dt_d            = dt_o;
        wc_d            = wc_o;
        frame_start_d   = 1'b0;
        frame_end_d     = 1'b0;
        line_start_d    = 1'b0;
        line_end_d      = 1'b0;
        packet_done_d   = 1'b0;
        err_truncated_d = 1'b0;
        aligner_clear_d = (state_d == ST_FLUSH);
        bytes_left_d    = bytes_left_q;
        data_left_d     = data_left_q;
        filtered_d      = filtered_q;

        case (state_q)
            ST_IDLE: begin
                if (lane_valid_i) begin
                    vc_d       = hdr_vc;
                    dt_d       = hdr_dt;
                    wc_d       = hdr_wc;
                    filtered_d = (VC_FILTER_EN == 1'b1) && (hdr_vc != VC_SEL);
                    if (hdr_is_long) begin
                        bytes_left_d = {1'b0, hdr_wc} + 17'd2;
                        data_left_d  = hdr_wc;
                    end else begin
                        packet_done_d = 1'b1;
                        case (hdr_dt)
                            6'h00:   frame_start_d = 1'b1;
                            6'h01:   frame_end_d   = 1'b1;
                            6'h02:   line_start_d  = 1'b1;
                            6'h03:   line_end_d    = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_PAYLOAD: begin
                if (lane_valid_i) begin
                    if ((data_left_q != 16'd0) && !filtered_q) begin
                        payload_valid_d = 1'b1;
                        payload_d       = lane_byte_i;
                        payload_be_d    = be_for_word;
                    end
                    data_left_d  = data_left_q - data_take;
                    bytes_left_d = is_last_word ? 17'd0 : (bytes_left_q - 17'd4);
                    if (is_last_word) begin
                        packet_done_d = 1'b1;
                    end
                end else begin
                    err_truncated_d = 1'b1;
                    packet_done_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // output and counter registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            payload_valid_o <= 1'b0;
            payload_o       <= 32'd0;
            payload_be_o    <= 4'd0;
            vc_o            <= 2'd0;
            dt_o            <= 6'd0;
            wc_o            <= 16'd0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            line_start_o    <= 1'b0;
            line_end_o      <= 1'b0;
            packet_done_o   <= 1'b0;
            aligner_clear_o <= 1'b0;
            err_truncated_o <= 1'b0;
            bytes_left_q    <= 17'd0;
            data_left_q     <= 16'd0;
            filtered_q      <= 1'b0;
        end else begin
            payload_valid_o <= payload_valid_d;
            payload_o       <= payload_d;
            payload_be_o    <= payload_be_d;
            vc_o            <= vc_d;
            dt_o            <= dt_d;
            wc_o            <= wc_d;
            frame_start_o   <= frame_start_d;
            frame_end_o     <= frame_end_d;
            line_start_o    <= line_start_d;
            line_end_o      <= line_end_d;
            packet_done_o   <= packet_done_d;
            aligner_clear_o <= aligner_clear_d;
            err_truncated_o <= err_truncated_d;
            bytes_left_q    <= bytes_left_d;
            data_left_q     <= data_left_d;
            filtered_q      <= filtered_d;
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_sequencer.sv
// Testbench for mipi_rx_packet_sequencer: a per-cycle vector table against an
// unfiltered instance, then hand-written sequences for virtual-channel
// filtering and reset in the middle of a payload.

module tb_mipi_rx_packet_sequencer;

    logic        clk;
    logic        reset;
    logic        lane_valid;
    logic [31:0] lane_byte;

    logic        pv0, fs0, fe0, ls0, le0, done0, clr0, err0;
    logic [31:0] pd0;
    logic [3:0]  be0;
    logic [1:0]  vc0;
    logic [5:0]  dt0;
    logic [15:0] wc0;

    logic        pv1, fs1, fe1, ls1, le1, done1, clr1, err1;
    logic [31:0] pd1;
    logic [3:0]  be1;
    logic [1:0]  vc1;
    logic [5:0]  dt1;
    logic [15:0] wc1;

    int n_checks;
    int n_fails;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] word;
        logic        pv;
        logic [3:0]  be;
        logic [31:0] pd;
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [3:0]  sync;
        logic        done;
        logic        clr;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    mipi_rx_packet_sequencer dut0 (
        .clk_i           (clk),
        .reset_i         (reset),
        .lane_valid_i    (lane_valid),
        .lane_byte_i     (lane_byte),
        .payload_valid_o (pv0),
        .payload_o       (pd0),
        .payload_be_o    (be0),
        .vc_o            (vc0),
        .dt_o            (dt0),
        .wc_o            (wc0),
        .frame_start_o   (fs0),
        .frame_end_o     (fe0),
        .line_start_o    (ls0),
        .line_end_o      (le0),
        .packet_done_o   (done0),
        .aligner_clear_o (clr0),
        .err_truncated_o (err0)
    );

    mipi_rx_packet_sequencer #(
        .VC_FILTER_EN (1'b1),
        .VC_SEL       (2'd0)
    ) dut1 (
        .clk_i           (clk),
        .reset_i         (reset),
        .lane_valid_i    (lane_valid),
        .lane_byte_i     (lane_byte),
        .payload_valid_o (pv1),
        .payload_o       (pd1),
        .payload_be_o    (be1),
        .vc_o            (vc1),
        .dt_o            (dt1),
        .wc_o            (wc1),
        .frame_start_o   (fs1),
        .frame_end_o     (fe1),
        .line_start_o    (ls1),
        .line_end_o      (le1),
        .packet_done_o   (done1),
        .aligner_clear_o (clr1),
        .err_truncated_o (err1)
    );

    // free-running byte clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic vld, logic [31:0] word,
                                logic pv, logic [3:0] be, logic [31:0] pd,
                                logic [1:0] vc, logic [5:0] dt, logic [15:0] wc,
                                logic [3:0] sync, logic done, logic clr, logic err);
        vec_t v;
        v.rst = rst;  v.vld = vld;  v.word = word;
        v.pv = pv;    v.be = be;    v.pd = pd;
        v.vc = vc;    v.dt = dt;    v.wc = wc;
        v.sync = sync; v.done = done; v.clr = clr; v.err = err;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic vld, input logic [31:0] word);
        reset      = rst;
        lane_valid = vld;
        lane_byte  = word;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        checkOutput({t, ".payload_valid"}, {31'd0, pv0}, {31'd0, v.pv});
        if (v.pv) begin
            checkOutput({t, ".payload_be"}, {28'd0, be0}, {28'd0, v.be});
            checkOutput({t, ".payload"}, pd0, v.pd);
        end
        checkOutput({t, ".vc"}, {30'd0, vc0}, {30'd0, v.vc});
        checkOutput({t, ".dt"}, {26'd0, dt0}, {26'd0, v.dt});
        checkOutput({t, ".wc"}, {16'd0, wc0}, {16'd0, v.wc});
        checkOutput({t, ".sync"}, {28'd0, le0, ls0, fe0, fs0}, {28'd0, v.sync});
        checkOutput({t, ".packet_done"}, {31'd0, done0}, {31'd0, v.done});
        checkOutput({t, ".aligner_clear"}, {31'd0, clr0}, {31'd0, v.clr});
        checkOutput({t, ".err_truncated"}, {31'd0, err0}, {31'd0, v.err});
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        reset      = 1'b1;
        lane_valid = 1'b0;
        lane_byte  = 32'd0;

        // reset and idle
        vecs.push_back(mk(1, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h00, 16'h0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h00, 16'h0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h00, 16'h0000, 4'b0000, 0, 0, 0));
        // frame start, VC=1, WC=5; flush holds while valid stays high
        vecs.push_back(mk(0, 1, 32'hEE000540, 0, 4'h0, 32'h0, 2'd1, 6'h00, 16'h0005, 4'b0001, 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'h12345678, 0, 4'h0, 32'h0, 2'd1, 6'h00, 16'h0005, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd1, 6'h00, 16'h0005, 4'b0000, 0, 0, 0));
        // long DT=0x2A WC=10: F, F, 3 then a trailing word absorbed by flush
        vecs.push_back(mk(0, 1, 32'hEE000A2A, 0, 4'h0, 32'h0, 2'd0, 6'h2A, 16'h000A, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h03020100, 1, 4'hF, 32'h03020100, 2'd0, 6'h2A, 16'h000A, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h07060504, 1, 4'hF, 32'h07060504, 2'd0, 6'h2A, 16'h000A, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hC1C00908, 1, 4'h3, 32'hC1C00908, 2'd0, 6'h2A, 16'h000A, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 4'h0, 32'h0, 2'd0, 6'h2A, 16'h000A, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h2A, 16'h000A, 4'b0000, 0, 0, 0));
        // line start VC=3 WC=0x1234
        vecs.push_back(mk(0, 1, 32'hEE1234C2, 0, 4'h0, 32'h0, 2'd3, 6'h02, 16'h1234, 4'b0100, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd3, 6'h02, 16'h1234, 4'b0000, 0, 0, 0));
        // frame end
        vecs.push_back(mk(0, 1, 32'hEE000001, 0, 4'h0, 32'h0, 2'd0, 6'h01, 16'h0000, 4'b0010, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h01, 16'h0000, 4'b0000, 0, 0, 0));
        // line end, WC=0x00FF
        vecs.push_back(mk(0, 1, 32'hEE00FF03, 0, 4'h0, 32'h0, 2'd0, 6'h03, 16'h00FF, 4'b1000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h03, 16'h00FF, 4'b0000, 0, 0, 0));
        // generic short DT=0x08: no sync pulse
        vecs.push_back(mk(0, 1, 32'hEE000108, 0, 4'h0, 32'h0, 2'd0, 6'h08, 16'h0001, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h08, 16'h0001, 4'b0000, 0, 0, 0));
        // long WC=0: one CRC word, no payload
        vecs.push_back(mk(0, 1, 32'hEE00006B, 0, 4'h0, 32'h0, 2'd1, 6'h2B, 16'h0000, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000ABCD, 0, 4'h0, 32'h0, 2'd1, 6'h2B, 16'h0000, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd1, 6'h2B, 16'h0000, 4'b0000, 0, 0, 0));
        // long WC=16 truncated after two words
        vecs.push_back(mk(0, 1, 32'hEE001024, 0, 4'h0, 32'h0, 2'd0, 6'h24, 16'h0010, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h11111111, 1, 4'hF, 32'h11111111, 2'd0, 6'h24, 16'h0010, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h22222222, 1, 4'hF, 32'h22222222, 2'd0, 6'h24, 16'h0010, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h24, 16'h0010, 4'b0000, 1, 1, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h24, 16'h0010, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h24, 16'h0010, 4'b0000, 0, 0, 0));
        // long WC=5 VC=2: BE F then 1, CRC shares the last word
        vecs.push_back(mk(0, 1, 32'hEE0005B0, 0, 4'h0, 32'h0, 2'd2, 6'h30, 16'h0005, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hA3A2A1A0, 1, 4'hF, 32'hA3A2A1A0, 2'd2, 6'h30, 16'h0005, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hC1C000A4, 1, 4'h1, 32'hC1C000A4, 2'd2, 6'h30, 16'h0005, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd2, 6'h30, 16'h0005, 4'b0000, 0, 0, 0));
        // long WC=3: BE 7, then a CRC-only word
        vecs.push_back(mk(0, 1, 32'hEE000312, 0, 4'h0, 32'h0, 2'd0, 6'h12, 16'h0003, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hC0B2B1B0, 1, 4'h7, 32'hC0B2B1B0, 2'd0, 6'h12, 16'h0003, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0000CCC1, 0, 4'h0, 32'h0, 2'd0, 6'h12, 16'h0003, 4'b0000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h12, 16'h0003, 4'b0000, 0, 0, 0));
        // header in the cycle right after flush exit
        vecs.push_back(mk(0, 1, 32'hEE000000, 0, 4'h0, 32'h0, 2'd0, 6'h00, 16'h0000, 4'b0001, 1, 1, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 4'h0, 32'h0, 2'd0, 6'h00, 16'h0000, 4'b0000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].word);
            checkVector(i, vecs[i]);
        end

        // filtered instance: VC=2 long WC=8 is consumed silently
        applyStimulus(0, 1, 32'hEE0008AA);
        checkOutput("filt.hdr_vc", {30'd0, vc1}, 32'd2);
        checkOutput("filt.hdr_dt", {26'd0, dt1}, 32'h2A);
        checkOutput("filt.hdr_wc", {16'd0, wc1}, 32'h8);
        applyStimulus(0, 1, 32'h44332211);
        checkOutput("filt.pv_w1", {31'd0, pv1}, 32'd0);
        checkOutput("filt.unfilt_pv_w1", {31'd0, pv0}, 32'd1);
        applyStimulus(0, 1, 32'h88776655);
        checkOutput("filt.pv_w2", {31'd0, pv1}, 32'd0);
        checkOutput("filt.done_early", {31'd0, done1}, 32'd0);
        applyStimulus(0, 1, 32'h0000C2C1);
        checkOutput("filt.pv_crc", {31'd0, pv1}, 32'd0);
        checkOutput("filt.done", {31'd0, done1}, 32'd1);
        checkOutput("filt.clr", {31'd0, clr1}, 32'd1);
        applyStimulus(0, 0, 32'h0);
        checkOutput("filt.clr_fall", {31'd0, clr1}, 32'd0);

        // next VC=0 packet passes the filter
        applyStimulus(0, 1, 32'hEE00042A);
        checkOutput("pass.hdr_vc", {30'd0, vc1}, 32'd0);
        applyStimulus(0, 1, 32'hCAFEF00D);
        checkOutput("pass.pv", {31'd0, pv1}, 32'd1);
        checkOutput("pass.be", {28'd0, be1}, 32'hF);
        checkOutput("pass.data", pd1, 32'hCAFEF00D);
        applyStimulus(0, 1, 32'h0000D1D2);
        checkOutput("pass.pv_crc", {31'd0, pv1}, 32'd0);
        checkOutput("pass.done", {31'd0, done1}, 32'd1);
        applyStimulus(0, 0, 32'h0);

        // short frame start on a filtered VC still pulses sync
        applyStimulus(0, 1, 32'hEE000080);
        checkOutput("filt_short.fs", {31'd0, fs1}, 32'd1);
        checkOutput("filt_short.vc", {30'd0, vc1}, 32'd2);
        checkOutput("filt_short.done", {31'd0, done1}, 32'd1);
        applyStimulus(0, 0, 32'h0);

        // reset on the second payload word of a WC=64 packet
        applyStimulus(0, 1, 32'hEE00402A);
        applyStimulus(0, 1, 32'h01010101);
        checkOutput("rst.pv_before", {31'd0, pv0}, 32'd1);
        applyStimulus(1, 1, 32'h02020202);
        checkOutput("rst.pv", {31'd0, pv0}, 32'd0);
        checkOutput("rst.payload", pd0, 32'd0);
        checkOutput("rst.be", {28'd0, be0}, 32'd0);
        checkOutput("rst.hdr", {8'd0, vc0, dt0, wc0}, 32'd0);
        checkOutput("rst.pulses", {26'd0, done0, err0, fs0, fe0, ls0, le0}, 32'd0);
        checkOutput("rst.clr", {31'd0, clr0}, 32'd0);
        applyStimulus(0, 1, 32'hEE000742);
        checkOutput("rst.new_hdr_ls", {31'd0, ls0}, 32'd1);
        checkOutput("rst.new_hdr_vc", {30'd0, vc0}, 32'd1);
        checkOutput("rst.new_hdr_wc", {16'd0, wc0}, 32'h7);
        checkOutput("rst.new_hdr_done", {31'd0, done0}, 32'd1);
        checkOutput("rst.new_hdr_err", {31'd0, err0}, 32'd0);
        applyStimulus(0, 0, 32'h0);
        checkOutput("rst.flush_exit", {31'd0, clr0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
